// File: rtl/dbus_lsu_master_pkg.sv
// Shared LSU/data-bus definitions: load/store op encoding, bus structs and defaults.
// Imported by the LSU master and its alignment helper.
package dbus_lsu_master_pkg;

    localparam int LSU_XLEN            = 32;
    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } type_lsu_op_e;

    typedef struct packed {
        logic                req;
        logic [LSU_XLEN-1:0] addr;
        logic                w_en;
        logic [LSU_XLEN-1:0] w_data;
        logic [3:0]          sel_byte;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [LSU_XLEN-1:0] r_data;
        logic                ack;
    } type_peri2dbus_s;

    function automatic logic is_store(input type_lsu_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/dbus_lsu_master_align.sv
// Combinational lane logic: store replication/byte enables, load extraction with
// sign/zero extension, and misalignment detection.
module dbus_lsu_master_align
    import dbus_lsu_master_pkg::*;
(
    input  type_lsu_op_e op_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [31:0]  wdata_i,
    input  logic [31:0]  rdata_i,
    output logic [31:0]  wdata_o,
    output logic [3:0]   sel_o,
    output logic [31:0]  ldata_o,
    output logic         misalign_o
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};

    // Store lane replication and byte enables; loads read the full word.
    always_comb begin
        wdata_o = 32'd0;
        sel_o   = 4'b1111;
        case (op_i)
            SB: begin
                wdata_o = {4{wdata_i[7:0]}};
                sel_o   = 4'b0001 << addr_lo_i;
            end
            SH: begin
                wdata_o = {2{wdata_i[15:0]}};
                sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            SW: begin
                wdata_o = wdata_i;
                sel_o   = 4'b1111;
            end
            default: begin
                wdata_o = 32'd0;
                sel_o   = 4'b1111;
            end
        endcase
    end

    // Load data extraction and extension.
    always_comb begin
        ldata_o = 32'd0;
        case (op_i)
            LB:      ldata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      ldata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LBU:     ldata_o = {24'd0, shifted_s[7:0]};
            LHU:     ldata_o = {16'd0, shifted_s[15:0]};
            LW:      ldata_o = shifted_s;
            default: ldata_o = 32'd0;
        endcase
    end

    // Halfwords need even addresses, words need 4-byte alignment.
    always_comb begin
        misalign_o = 1'b0;
        case (op_i)
            LH, LHU, SH: misalign_o = addr_lo_i[0];
            LW, SW:      misalign_o = (addr_lo_i != 2'b00);
            default:     misalign_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dbus_lsu_master.sv
// Data-bus initiator: accepts one load/store from execute, runs a single bus
// access with timeout, and returns extended load data with a done pulse.
module dbus_lsu_master
    import dbus_lsu_master_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_req_i,
    input  logic [2:0]      lsu_op_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_busy_o,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_misalign_o,
    output logic            lsu_bus_err_o,
    output type_dbus2peri_s dbus_o,
    input  type_peri2dbus_s dbus_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e       state_q, state_d;
    type_lsu_op_e op_q, op_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   sel_q, sel_d;
    logic         wen_q, wen_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         misal_q, misal_d;
    logic         berr_q, berr_d;
    logic [31:0]  rdata_q, rdata_d;

    type_lsu_op_e al_op_s;
    logic [1:0]   al_addr_lo_s;
    logic [31:0]  al_wdata_s;
    logic [3:0]   al_sel_s;
    logic [31:0]  al_ldata_s;
    logic         al_misalign_s;

    // In IDLE the helper sees the incoming request; otherwise the latched one.
    assign al_op_s      = (state_q == ST_IDLE) ? type_lsu_op_e'(lsu_op_i) : op_q;
    assign al_addr_lo_s = (state_q == ST_IDLE) ? lsu_addr_i[1:0] : addr_q[1:0];

    dbus_lsu_master_align u_align (
        .op_i       (al_op_s),
        .addr_lo_i  (al_addr_lo_s),
        .wdata_i    (lsu_wdata_i),
        .rdata_i    (dbus_i.r_data),
        .wdata_o    (al_wdata_s),
        .sel_o      (al_sel_s),
        .ldata_o    (al_ldata_s),
        .misalign_o (al_misalign_s)
    );

    // Next-state logic; registered status outputs are computed from the next state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        misal_d = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    op_d    = type_lsu_op_e'(lsu_op_i);
                    addr_d  = lsu_addr_i;
                    wdata_d = al_wdata_s;
                    sel_d   = al_sel_s;
                    wen_d   = is_store(type_lsu_op_e'(lsu_op_i));
                    if (al_misalign_s) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        misal_d = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = ST_BUS;
                        busy_d  = 1'b1;
                        cnt_d   = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (dbus_i.ack) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = is_store(op_q) ? 32'd0 : al_ldata_s;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES))) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    // With the timeout disabled the counter is left to wrap harmlessly.
                    cnt_d  = cnt_q + 32'd1;
                    busy_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= LB;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            wen_q   <= 1'b0;
            cnt_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            misal_q <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            misal_q <= misal_d;
            berr_q  <= berr_d;
            rdata_q <= rdata_d;
        end
    end

    // Request is masked by ack combinationally so the slave never samples it twice.
    always_comb begin
        dbus_o          = '0;
        dbus_o.req      = (state_q == ST_BUS) & ~dbus_i.ack;
        dbus_o.addr     = {addr_q[31:2], 2'b00};
        dbus_o.w_en     = wen_q;
        dbus_o.w_data   = wdata_q;
        dbus_o.sel_byte = sel_q;
    end

    assign lsu_busy_o     = busy_q;
    assign lsu_done_o     = done_q;
    assign lsu_rdata_o    = rdata_q;
    assign lsu_misalign_o = misal_q;
    assign lsu_bus_err_o  = berr_q;

endmodule

// File: tb/tb_dbus_lsu_master.sv
// Directed bench for dbus_lsu_master with a bench-driven zero-wait slave,
// misalign, timeout (TIMEOUT_CYCLES=8) and mid-access reset cases.
module tb_dbus_lsu_master;
    import dbus_lsu_master_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lsu_req_i;
    logic [2:0]      lsu_op_i;
    logic [31:0]     lsu_addr_i;
    logic [31:0]     lsu_wdata_i;
    logic            lsu_busy_o;
    logic            lsu_done_o;
    logic [31:0]     lsu_rdata_o;
    logic            lsu_misalign_o;
    logic            lsu_bus_err_o;
    type_dbus2peri_s dbus_o;
    type_peri2dbus_s dbus_i;

    int vectors = 0;
    int fails   = 0;

    int          r_req_cnt, r_done_cyc;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata, r_addr, r_rdata;
    logic        r_wen, r_mis, r_berr, r_busy1, r_busy_resp;

    dbus_lsu_master #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_req_i      (lsu_req_i),
        .lsu_op_i       (lsu_op_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_busy_o     (lsu_busy_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_misalign_o (lsu_misalign_o),
        .lsu_bus_err_o  (lsu_bus_err_o),
        .dbus_o         (dbus_o),
        .dbus_i         (dbus_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access; slave acks one cycle after it sees req when ack_en is set.
    // hold keeps lsu_req_i asserted (with different op/addr) to prove it is ignored.
    task automatic access(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] slave_rdata,
                          input logic ack_en, input logic hold);
        logic last_req;
        r_req_cnt = 0; r_done_cyc = 0; r_sel = 4'd0; r_wdata = 32'd0; r_addr = 32'd0;
        r_wen = 1'b0; r_rdata = 32'd0; r_mis = 1'b0; r_berr = 1'b0;
        r_busy1 = 1'b0; r_busy_resp = 1'b1;
        last_req = 1'b0;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_op_i = op; lsu_addr_i = addr; lsu_wdata_i = wdata;
        dbus_i.r_data = slave_rdata; dbus_i.ack = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                lsu_op_i = 3'd5; lsu_addr_i = 32'h0000_0300;
            end else begin
                lsu_req_i = 1'b0;
            end
            dbus_i.ack = ack_en & last_req;
            @(negedge clk);
            if (i == 1) r_busy1 = lsu_busy_o;
            if (lsu_done_o) begin
                r_done_cyc = i; r_rdata = lsu_rdata_o; r_mis = lsu_misalign_o;
                r_berr = lsu_bus_err_o; r_busy_resp = lsu_busy_o;
                lsu_req_i = 1'b0;
                break;
            end
            last_req = dbus_o.req;
            if (dbus_o.req) begin
                r_req_cnt++;
                r_sel = dbus_o.sel_byte; r_wdata = dbus_o.w_data;
                r_addr = dbus_o.addr; r_wen = dbus_o.w_en;
            end
        end
        lsu_req_i = 1'b0;
        dbus_i.ack = 1'b0;
        if (r_done_cyc == 0) check("done_never_seen", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; lsu_req_i = 1'b0; lsu_op_i = 3'd0; lsu_addr_i = 32'd0;
        lsu_wdata_i = 32'd0; dbus_i = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   {31'd0, dbus_o.req}, 32'd0);
        check("rst_busy",  {31'd0, lsu_busy_o}, 32'd0);
        check("rst_done",  {31'd0, lsu_done_o}, 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'd0);
        check("rst_sel",   {28'd0, dbus_o.sel_byte}, 32'd0);
        rst_n = 1'b1;

        // SW 0x100, execute keeps requesting something else while stalled
        access(3'd7, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
        check("sw_req_cycles", r_req_cnt, 32'd1);
        check("sw_done_cyc",   r_done_cyc, 32'd3);
        check("sw_sel",        {28'd0, r_sel}, 32'h0000_000F);
        check("sw_wdata",      r_wdata, 32'hDEAD_BEEF);
        check("sw_addr",       r_addr, 32'h0000_0100);
        check("sw_wen",        {31'd0, r_wen}, 32'd1);
        check("sw_busy",       {31'd0, r_busy1}, 32'd1);
        check("sw_busy_resp",  {31'd0, r_busy_resp}, 32'd0);
        check("sw_errs",       {30'd0, r_mis, r_berr}, 32'd0);
        check("sw_idle_after", {31'd0, lsu_done_o | lsu_busy_o | dbus_o.req}, 32'd0);

        access(3'd5, 32'h0000_0103, 32'h0000_00A5, 32'd0, 1'b1, 1'b0);
        check("sb_sel",   {28'd0, r_sel}, 32'h0000_0008);
        check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        check("sb_addr",  r_addr, 32'h0000_0100);

        access(3'd0, 32'h0000_0103, 32'd0, 32'hA500_0000, 1'b1, 1'b0);
        check("lb_rdata",  r_rdata, 32'hFFFF_FFA5);
        check("lb_sel",    {28'd0, r_sel}, 32'h0000_000F);
        check("lb_wen",    {31'd0, r_wen}, 32'd0);
        check("lb_wdata",  r_wdata, 32'd0);
        access(3'd3, 32'h0000_0103, 32'd0, 32'hA500_0000, 1'b1, 1'b0);
        check("lbu_rdata", r_rdata, 32'h0000_00A5);

        access(3'd1, 32'h0000_0102, 32'd0, 32'h8001_1234, 1'b1, 1'b0);
        check("lh_rdata",  r_rdata, 32'hFFFF_8001);
        access(3'd4, 32'h0000_0102, 32'd0, 32'h8001_1234, 1'b1, 1'b0);
        check("lhu_rdata", r_rdata, 32'h0000_8001);

        access(3'd6, 32'h0000_0102, 32'h0000_BEEF, 32'd0, 1'b1, 1'b0);
        check("sh_hi_sel",   {28'd0, r_sel}, 32'h0000_000C);
        check("sh_hi_wdata", r_wdata, 32'hBEEF_BEEF);

        access(3'd2, 32'h0000_0101, 32'd0, 32'h1234_5678, 1'b1, 1'b0);
        check("lw_mis_flag", {31'd0, r_mis}, 32'd1);
        check("lw_mis_cyc",  r_done_cyc, 32'd1);
        check("lw_mis_req",  r_req_cnt, 32'd0);
        check("lw_mis_berr", {31'd0, r_berr}, 32'd0);
        access(3'd6, 32'h0000_0103, 32'h0000_1111, 32'd0, 1'b1, 1'b0);
        check("sh_mis_flag", {31'd0, r_mis}, 32'd1);
        check("sh_mis_cyc",  r_done_cyc, 32'd1);
        check("sh_mis_req",  r_req_cnt, 32'd0);

        access(3'd2, 32'h0000_0204, 32'd0, 32'hCAFE_F00D, 1'b1, 1'b0);
        check("lw_rdata", r_rdata, 32'hCAFE_F00D);
        access(3'd2, 32'h0000_0200, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("to_req_cycles", r_req_cnt, 32'd8);
        check("to_done_cyc",   r_done_cyc, 32'd9);
        check("to_berr",       {31'd0, r_berr}, 32'd1);
        check("to_rdata",      r_rdata, 32'd0);
        check("to_idle",       {31'd0, lsu_busy_o | dbus_o.req | lsu_done_o}, 32'd0);

        // Reset while in BUS, then a late ack
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_op_i = 3'd7; lsu_addr_i = 32'h0000_0400;
        lsu_wdata_i = 32'h0123_4567; dbus_i.ack = 1'b0;
        @(posedge clk);
        #1;
        lsu_req_i = 1'b0;
        @(negedge clk);
        check("rstbus_req_before", {31'd0, dbus_o.req}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstbus_req_after", {31'd0, dbus_o.req}, 32'd0);
        rst_n = 1'b1;
        dbus_i.ack = 1'b1;
        dbus_i.r_data = 32'h5555_AAAA;
        @(negedge clk);
        check("rstbus_done",  {31'd0, lsu_done_o}, 32'd0);
        check("rstbus_busy",  {31'd0, lsu_busy_o}, 32'd0);
        check("rstbus_wen",   {31'd0, dbus_o.w_en}, 32'd0);
        check("rstbus_addr",  dbus_o.addr, 32'd0);
        check("rstbus_wdata", dbus_o.w_data, 32'd0);
        @(posedge clk);
        #1;
        dbus_i.ack = 1'b0;
        @(negedge clk);
        check("late_ack_done",  {31'd0, lsu_done_o}, 32'd0);
        check("late_ack_rdata", lsu_rdata_o, 32'd0);
        check("late_ack_flags", {30'd0, lsu_misalign_o, lsu_bus_err_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
